// File: rtl/axi_burst_serializer.sv
// Replays one scheduled packet (metadata + up to MAX_BEATS beats) per handshake as an AXI4 AR burst
// or AW+W burst, tracking outstanding B/R completions and flagging length and response errors.
module axi_burst_serializer #(
  parameter int C_M_AXI_ID_WIDTH   = 16,
  parameter int C_M_AXI_ADDR_WIDTH = 40,
  parameter int C_M_AXI_DATA_WIDTH = 128,
  parameter int MAX_BEATS          = 4,
  parameter int MAX_OUTSTANDING    = 4,
  localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8,
  localparam int META_W = C_M_AXI_ADDR_WIDTH + C_M_AXI_ID_WIDTH + 30,
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1),
  localparam int PKT_W  = META_W + MAX_BEATS * (C_M_AXI_DATA_WIDTH + STRB_W)
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESET,
  input  logic [PKT_W-1:0]              packet_in,
  input  logic                          packet_valid,
  output logic                          packet_ready,
  output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [7:0]                    M_AXI_AWLEN,
  output logic [2:0]                    M_AXI_AWSIZE,
  output logic [1:0]                    M_AXI_AWBURST,
  output logic                          M_AXI_AWLOCK,
  output logic [3:0]                    M_AXI_AWCACHE,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic [3:0]                    M_AXI_AWQOS,
  output logic [3:0]                    M_AXI_AWREGION,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [STRB_W-1:0]             M_AXI_WSTRB,
  output logic                          M_AXI_WLAST,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic                          M_AXI_BVALID,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_BID,
  output logic                          M_AXI_BREADY,
  output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARLOCK,
  output logic [3:0]                    M_AXI_ARCACHE,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic [3:0]                    M_AXI_ARQOS,
  output logic [3:0]                    M_AXI_ARREGION,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic                          M_AXI_RVALID,
  input  logic                          M_AXI_RLAST,
  input  logic [1:0]                    M_AXI_RRESP,
  output logic                          M_AXI_RREADY,
  output logic [CNT_W-1:0]              outstanding,
  output logic                          err_len,
  output logic                          err_resp
);
  localparam int DW        = C_M_AXI_DATA_WIDTH;
  localparam int IDX_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int DATA_BITS = MAX_BEATS * DW;
  localparam int META_LSB  = DATA_BITS + MAX_BEATS * STRB_W;
  localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, AR, AW, W} state_t;

  state_t           state_reg, state_next;
  logic [PKT_W-1:0] pkt_reg;
  logic [IDX_W-1:0] beat_idx_reg, beat_idx_next;
  logic [CNT_W-1:0] outstanding_reg, outstanding_next;
  logic             packet_ready_reg, resp_ready_reg, err_len_reg, err_resp_reg;

  logic       in_type, len_ok, pkt_fire, ar_fire, aw_fire, w_fire, r_done, b_done, wlast_int;
  logic [7:0] in_len, m_len;
  logic [CNT_W:0] cnt_sum, cnt_dec, cnt_diff;

  // The accept decision looks at the incoming packet; everything driven afterwards uses pkt_reg.
  assign in_type  = packet_in[PKT_W-1];
  assign in_len   = packet_in[META_LSB+21 +: 8];
  assign len_ok   = 32'(in_len) < 32'(MAX_BEATS);
  assign m_len    = pkt_reg[META_LSB+21 +: 8];

  logic [DW-1:0]     beat_data [MAX_BEATS];
  logic [STRB_W-1:0] beat_strb [MAX_BEATS];
  for (genvar gi = 0; gi < MAX_BEATS; gi++) begin : g_beat
    assign beat_data[gi] = pkt_reg[(MAX_BEATS-1-gi)*DW +: DW];
    assign beat_strb[gi] = pkt_reg[DATA_BITS + (MAX_BEATS-1-gi)*STRB_W +: STRB_W];
  end

  assign pkt_fire  = packet_valid & packet_ready_reg;
  assign ar_fire   = (state_reg == AR) & M_AXI_ARREADY;
  assign aw_fire   = (state_reg == AW) & M_AXI_AWREADY;
  assign w_fire    = (state_reg == W) & M_AXI_WREADY;
  assign wlast_int = (state_reg == W) && (8'(beat_idx_reg) == m_len);
  assign r_done    = M_AXI_RVALID & M_AXI_RLAST & resp_ready_reg;
  assign b_done    = M_AXI_BVALID & resp_ready_reg;

  // Both address channels share the held metadata; only the VALIDs differ.
  assign M_AXI_AWREGION = pkt_reg[META_LSB +: 4];
  assign M_AXI_AWQOS    = pkt_reg[META_LSB+4 +: 4];
  assign M_AXI_AWPROT   = pkt_reg[META_LSB+8 +: 3];
  assign M_AXI_AWCACHE  = pkt_reg[META_LSB+11 +: 4];
  assign M_AXI_AWLOCK   = pkt_reg[META_LSB+15];
  assign M_AXI_AWBURST  = pkt_reg[META_LSB+16 +: 2];
  assign M_AXI_AWSIZE   = pkt_reg[META_LSB+18 +: 3];
  assign M_AXI_AWLEN    = m_len;
  assign M_AXI_AWID     = pkt_reg[META_LSB+29 +: C_M_AXI_ID_WIDTH];
  assign M_AXI_AWADDR   = pkt_reg[META_LSB+29+C_M_AXI_ID_WIDTH +: C_M_AXI_ADDR_WIDTH];
  assign M_AXI_AWVALID  = (state_reg == AW);
  assign M_AXI_ARREGION = M_AXI_AWREGION;
  assign M_AXI_ARQOS    = M_AXI_AWQOS;
  assign M_AXI_ARPROT   = M_AXI_AWPROT;
  assign M_AXI_ARCACHE  = M_AXI_AWCACHE;
  assign M_AXI_ARLOCK   = M_AXI_AWLOCK;
  assign M_AXI_ARBURST  = M_AXI_AWBURST;
  assign M_AXI_ARSIZE   = M_AXI_AWSIZE;
  assign M_AXI_ARLEN    = m_len;
  assign M_AXI_ARID     = M_AXI_AWID;
  assign M_AXI_ARADDR   = M_AXI_AWADDR;
  assign M_AXI_ARVALID  = (state_reg == AR);
  assign M_AXI_WDATA    = beat_data[beat_idx_reg];
  assign M_AXI_WSTRB    = beat_strb[beat_idx_reg];
  assign M_AXI_WLAST    = wlast_int;
  assign M_AXI_WVALID   = (state_reg == W);
  assign M_AXI_BREADY   = resp_ready_reg;
  assign M_AXI_RREADY   = resp_ready_reg;
  assign packet_ready   = packet_ready_reg;
  assign outstanding    = outstanding_reg;
  assign err_len        = err_len_reg;
  assign err_resp       = err_resp_reg;

  always_comb begin
    state_next    = state_reg;
    beat_idx_next = beat_idx_reg;
    case (state_reg)
      IDLE: if (pkt_fire) begin
        if (!in_type)    state_next = AR;
        else if (len_ok) state_next = AW;
      end
      AR: if (ar_fire) state_next = IDLE;
      AW: if (aw_fire) begin
        state_next    = W;
        beat_idx_next = '0;
      end
      W: if (w_fire) begin
        if (wlast_int) state_next = IDLE;
        else           beat_idx_next = beat_idx_reg + 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Saturating up/down count: completions at zero are dropped, never wrap.
  always_comb begin
    cnt_sum  = {1'b0, outstanding_reg} + (CNT_W+1)'(ar_fire | aw_fire);
    cnt_dec  = (CNT_W+1)'(r_done) + (CNT_W+1)'(b_done);
    cnt_diff = (cnt_sum > cnt_dec) ? (cnt_sum - cnt_dec) : '0;
    outstanding_next = (cnt_diff > {1'b0, MAX_OUT}) ? MAX_OUT : cnt_diff[CNT_W-1:0];
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_reg        <= IDLE;
      beat_idx_reg     <= '0;
      outstanding_reg  <= '0;
      pkt_reg          <= '0;
      packet_ready_reg <= 1'b0;
      resp_ready_reg   <= 1'b0;
      err_len_reg      <= 1'b0;
      err_resp_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      beat_idx_reg     <= beat_idx_next;
      outstanding_reg  <= outstanding_next;
      packet_ready_reg <= (state_reg == IDLE) && (state_next == IDLE) && (outstanding_next < MAX_OUT);
      resp_ready_reg   <= 1'b1;
      if (pkt_fire) pkt_reg <= packet_in;
      if (pkt_fire && in_type && !len_ok) err_len_reg <= 1'b1;
      if ((b_done && M_AXI_BRESP[1]) || (r_done && M_AXI_RRESP[1])) err_resp_reg <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_burst_serializer.sv
// Directed bench for axi_burst_serializer: read/write bursts, length drop, outstanding limit,
// response errors and mid-burst reset.
module tb_axi_burst_serializer;
  localparam int IDW = 16, AW = 40, DW = 128, MB = 4, MO = 4, SW = 16;
  localparam int META_W = AW + IDW + 30;
  localparam int PKT_W  = META_W + MB * (DW + SW);
  localparam int CNT_W  = 3;

  logic clk = 1'b0, rst;
  logic [PKT_W-1:0] packet_in;
  logic packet_valid, packet_ready;
  logic [IDW-1:0] awid, arid, bid;
  logic [AW-1:0]  awaddr, araddr;
  logic [7:0]     awlen, arlen;
  logic [2:0]     awsize, arsize, awprot, arprot;
  logic [1:0]     awburst, arburst, bresp, rresp;
  logic           awlock, arlock, awvalid, arvalid, awready, arready;
  logic [3:0]     awcache, arcache, awqos, arqos, awregion, arregion;
  logic [DW-1:0]  wdata;
  logic [SW-1:0]  wstrb;
  logic           wlast, wvalid, wready, bvalid, bready, rvalid, rlast, rready;
  logic [CNT_W-1:0] outstanding;
  logic           err_len, err_resp;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  axi_burst_serializer dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .packet_in(packet_in), .packet_valid(packet_valid), .packet_ready(packet_ready),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache), .M_AXI_AWPROT(awprot),
    .M_AXI_AWQOS(awqos), .M_AXI_AWREGION(awregion), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_BVALID(bvalid), .M_AXI_BRESP(bresp), .M_AXI_BID(bid), .M_AXI_BREADY(bready),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot),
    .M_AXI_ARQOS(arqos), .M_AXI_ARREGION(arregion), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RVALID(rvalid), .M_AXI_RLAST(rlast), .M_AXI_RRESP(rresp), .M_AXI_RREADY(rready),
    .outstanding(outstanding), .err_len(err_len), .err_resp(err_resp)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [SW-1:0] exp_strb(input logic distinct, input int i);
    return distinct ? (16'h0F00 | (16'h0001 << i)) : 16'hFFFF;
  endfunction

  function automatic logic [PKT_W-1:0] mk_pkt(input logic wr, input logic [AW-1:0] addr,
      input logic [IDW-1:0] id, input logic [7:0] len, input logic [DW-1:0] base, input logic distinct);
    logic [META_W-1:0] meta;
    logic [MB*SW-1:0]  strbs;
    logic [MB*DW-1:0]  datas;
    meta = {wr, addr, id, len, 3'd4, 2'b01, 1'b1, 4'b0011, 3'b010, 4'h9, 4'h6};
    for (int i = 0; i < MB; i++) begin
      strbs[(MB-1-i)*SW +: SW] = exp_strb(distinct, i);
      datas[(MB-1-i)*DW +: DW] = base + DW'(i);
    end
    return {meta, strbs, datas};
  endfunction

  // Waits (bounded) for packet_ready, presents one packet for one cycle; returns on the
  // negedge after the accepting clock edge.
  task automatic send_pkt(input logic [PKT_W-1:0] p);
    int n = 0;
    while (!packet_ready && n < 50) begin @(negedge clk); n++; end
    check("send_ready", packet_ready, 1'b1);
    packet_in = p; packet_valid = 1'b1;
    @(negedge clk);
    packet_valid = 1'b0;
  endtask

  task automatic collect_beats(input logic [7:0] len, input logic [DW-1:0] base,
      input logic distinct, input logic toggle);
    int k = 0;
    logic done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      wready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (wvalid && wready) begin
        $display("W beat %0d data=%0h strb=%0h last=%0b", k, wdata, wstrb, wlast);
        check($sformatf("wdata%0d", k), wdata, base + DW'(k));
        check($sformatf("wstrb%0d", k), wstrb, exp_strb(distinct, k));
        check($sformatf("wlast%0d", k), wlast, k == int'(len));
        done = wlast;
        k++;
      end
      @(negedge clk);
    end
    wready = 1'b0;
    check("beat_count", k, int'(len) + 1);
  endtask

  task automatic pulse_b(input logic [1:0] resp);
    bvalid = 1'b1; bresp = resp;
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1; packet_in = '0; packet_valid = 1'b0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00; bid = '0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_ready", packet_ready, 1'b0);
    check("rst_outstanding", outstanding, 0);
    check("rst_valids", {arvalid, awvalid, wvalid, wlast}, 4'b0000);
    check("rst_resp_ready", {bready, rready}, 2'b00);
    check("rst_errs", {err_len, err_resp}, 2'b00);
    check("rst_addr", awaddr, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {packet_ready, bready, rready}, 3'b111);

    // Read burst with ARREADY tied high
    arready = 1'b1; awready = 1'b1;
    send_pkt(mk_pkt(1'b0, 40'h40_0000_1000, 16'h5, 8'd3, '0, 1'b0));
    $display("AR addr=%0h id=%0h len=%0d", araddr, arid, arlen);
    check("ar_valid", arvalid, 1'b1);
    check("ar_addr", araddr, 40'h40_0000_1000);
    check("ar_id", arid, 16'h5);
    check("ar_len", arlen, 8'd3);
    check("ar_attrs", {arsize, arburst, arlock, arcache, arprot, arqos, arregion},
          {3'd4, 2'b01, 1'b1, 4'b0011, 3'b010, 4'h9, 4'h6});
    @(negedge clk);
    check("ar_one_cycle", arvalid, 1'b0);
    check("rd_outstanding1", outstanding, 1);
    rvalid = 1'b1; rlast = 1'b1;
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    check("rd_outstanding0", outstanding, 0);

    // Write burst, WREADY toggling
    send_pkt(mk_pkt(1'b1, 40'h12_3456_7890, 16'hA, 8'd3, 128'hA0, 1'b0));
    $display("AW addr=%0h id=%0h len=%0d", awaddr, awid, awlen);
    check("aw_valid", awvalid, 1'b1);
    check("aw_before_w", wvalid, 1'b0);
    check("aw_addr", awaddr, 40'h12_3456_7890);
    check("aw_len", awlen, 8'd3);
    @(negedge clk);
    check("aw_done", awvalid, 1'b0);
    check("wr_outstanding1", outstanding, 1);
    collect_beats(8'd3, 128'hA0, 1'b0, 1'b1);
    check("w_idle", wvalid, 1'b0);
    pulse_b(2'b00);
    check("wr_outstanding0", outstanding, 0);

    // Over-long write is dropped
    check("err_len_pre", err_len, 1'b0);
    send_pkt(mk_pkt(1'b1, 40'h1000, 16'h1, 8'd7, 128'hF0, 1'b0));
    check("err_len", err_len, 1'b1);
    check("drop_ready", packet_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (awvalid || wvalid) seen++;
      @(negedge clk);
    end
    check("drop_no_axi", seen, 0);

    // Outstanding limit with no R responses
    for (int i = 0; i < 4; i++) send_pkt(mk_pkt(1'b0, 40'(64 * i), 16'(i), 8'd0, '0, 1'b0));
    repeat (2) @(negedge clk);
    check("limit_count", outstanding, 4);
    check("limit_ready", packet_ready, 1'b0);
    packet_in = mk_pkt(1'b0, 40'h77, 16'h7, 8'd0, '0, 1'b0); packet_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("limit_hold", {packet_ready, arvalid}, 2'b00);
    rvalid = 1'b1; rlast = 1'b1;
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    check("limit_dec", outstanding, 3);
    check("limit_reopen", packet_ready, 1'b1);
    @(negedge clk);
    packet_valid = 1'b0;
    check("fifth_ar", {arvalid, araddr}, {1'b1, 40'h77});
    @(negedge clk);
    check("fifth_count", outstanding, 4);
    rvalid = 1'b1; rlast = 1'b1;
    repeat (5) @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    check("drain_no_underflow", outstanding, 0);

    // Error response and simultaneous increment/decrement
    check("err_resp_pre", err_resp, 1'b0);
    send_pkt(mk_pkt(1'b1, 40'h2000, 16'h3, 8'd0, 128'hC0, 1'b1));
    @(negedge clk);
    collect_beats(8'd0, 128'hC0, 1'b1, 1'b0);
    pulse_b(2'b10);
    check("err_resp_set", err_resp, 1'b1);
    check("slverr_outstanding", outstanding, 0);
    repeat (3) @(negedge clk);
    check("err_resp_sticky", err_resp, 1'b1);
    send_pkt(mk_pkt(1'b0, 40'h3000, 16'h4, 8'd1, '0, 1'b0));
    @(negedge clk);
    check("sim_pre", outstanding, 1);
    arready = 1'b0;
    send_pkt(mk_pkt(1'b0, 40'h3100, 16'h5, 8'd1, '0, 1'b0));
    @(negedge clk);
    check("ar_held", arvalid, 1'b1);
    arready = 1'b1; rvalid = 1'b1; rlast = 1'b1;
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    check("sim_unchanged", outstanding, 1);
    check("sim_ar_done", arvalid, 1'b0);
    rvalid = 1'b1; rlast = 1'b1;
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    check("sim_drain", outstanding, 0);

    // Reset during beat 2 of a 4-beat write
    wready = 1'b1;
    send_pkt(mk_pkt(1'b1, 40'h4000, 16'h8, 8'd3, 128'hD0, 1'b1));
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("mid_beat2", wdata, 128'hD2);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valids", {arvalid, awvalid, wvalid, wlast}, 4'b0000);
    check("mid_rst_count", outstanding, 0);
    check("mid_rst_err", err_resp, 1'b0);
    rst = 1'b0; wready = 1'b0;
    @(negedge clk);
    send_pkt(mk_pkt(1'b1, 40'h5000, 16'h9, 8'd1, 128'hE0, 1'b1));
    check("fresh_aw", {awvalid, awaddr}, {1'b1, 40'h5000});
    @(negedge clk);
    collect_beats(8'd1, 128'hE0, 1'b1, 1'b0);
    pulse_b(2'b00);
    check("fresh_done", outstanding, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_burst_serializer.md
Name: axi_burst_serializer

Overview:
- Parametrised successor of the single-shot packet serializer in the MemorEDF datapath.
- Accepts one scheduled packet per valid/ready handshake from the EDF scheduler. A packet is a metadata word plus up to MAX_BEATS data/strobe beats.
- Replays each packet onto an AXI4 master port as either one AR burst or one AW+W burst.
- Generalises beat count, widths and outstanding depth. Adds B/R completion tracking, backpressure, length checking and response-error flags.

Parameters:
- C_M_AXI_ID_WIDTH, 16, AXI ID width.
- C_M_AXI_ADDR_WIDTH, 40, AXI address width.
- C_M_AXI_DATA_WIDTH, 128, AXI data width; strobe width STRB_W = DATA/8.
- MAX_BEATS, 4, maximum beats per packet (>=1).
- MAX_OUTSTANDING, 4, maximum issued-but-uncompleted transactions (>=1); counter width CNT_W = clog2(MAX_OUTSTANDING+1).
- META_W (derived), ADDR+ID+30, metadata width.

Ports:
- M_AXI_ACLK  in  1  clock; all logic on rising edge.
- M_AXI_ARESET  in  1  synchronous, active-high reset.
- packet_in  in  META_W+MAX_BEATS*(DATA+STRB_W)  packet.
  - MSB-first layout: meta, strb[0..MAX_BEATS-1], data[0..MAX_BEATS-1].
  - Meta layout, MSB-first: type(1=write), addr, id, len[7:0], size[2:0], burst[1:0], lock, cache[3:0], prot[2:0], qos[3:0], region[3:0].
- packet_valid  in  1  packet_in is valid.
- packet_ready  out  1  packet accepted when valid&ready.
- M_AXI_AW*  out  AXI4 write-address channel fields ID, ADDR, LEN, SIZE, BURST, LOCK, CACHE, PROT, QOS, REGION, VALID; AWREADY in.
- M_AXI_W*  out  WDATA, WSTRB, WLAST, WVALID; WREADY in.
- M_AXI_B*  in  BVALID, BRESP[1:0], BID; BREADY out.
- M_AXI_AR*  out  AXI4 read-address channel, same field set as AW; ARREADY in.
- M_AXI_R*  in  RVALID, RLAST, RRESP[1:0]; RREADY out.
- outstanding  out  CNT_W  current outstanding transaction count.
- err_len  out  1  sticky: a packet was dropped because len+1 > MAX_BEATS.
- err_resp  out  1  sticky: a BRESP or RRESP of SLVERR/DECERR was seen.

Behaviour:
- Reset, held while M_AXI_ARESET=1:
  - state=IDLE; all VALIDs and WLAST 0.
  - packet_ready=0; outstanding=0; err_len=0; err_resp=0.
  - BREADY=RREADY=0; address/data outputs 0.
  - Reset mid-burst abandons the burst without completing it.
- BREADY=RREADY=1 in every non-reset cycle. R data is discarded; only RLAST/RRESP are used.
- packet_ready=1 iff state==IDLE and outstanding<MAX_OUTSTANDING. It is a registered output.
- On a packet handshake the whole packet is captured into a holding register. All channel outputs come from this register, never from packet_in.
- FSM states: IDLE, AR, AW, W.
  - IDLE -> AR when type=0: ARVALID=1 on the next cycle.
  - IDLE -> AW when type=1 and len+1<=MAX_BEATS: AWVALID=1 on the next cycle.
  - IDLE stays IDLE when type=1 and len+1>MAX_BEATS: packet dropped, err_len set next cycle, no AXI activity.
  - Read packets are never length-checked.
  - AR: hold ARVALID and fields until ARREADY. On handshake: ARVALID=0, outstanding++, -> IDLE.
  - AW: hold AWVALID until AWREADY. On handshake: outstanding++, -> W. WVALID=1 and beat index=0 on the next cycle.
  - W: WDATA/WSTRB = beat[index]; WLAST=(index==len).
    - On WVALID&WREADY with !WLAST: index++.
    - On WVALID&WREADY with WLAST: WVALID=0, -> IDLE.
    - W never starts before the AW handshake.
- Outstanding counter:
  - Increments on ARVALID&ARREADY or AWVALID&AWREADY.
  - Decrements on RVALID&RLAST or on BVALID.
  - An increment and a decrement in the same cycle leave it unchanged.
  - It never exceeds MAX_OUTSTANDING, and a completion while at 0 is ignored without underflow.
- err_resp is set when BVALID or RVALID&RLAST arrives with resp[1]=1. It is cleared only by reset.
- Throughput:
  - Read: handshake -> ARVALID is 1 cycle; minimum 3 cycles per read packet.
  - Write of N beats: minimum N+3 cycles.

Test Plan:
- Read packet, id=0x5, addr=0x40_0000_1000, len=3, ARREADY tied 1 -> ARVALID for exactly 1 cycle, 1 cycle after handshake, fields match; outstanding=1; after RVALID&RLAST outstanding=0.
- Write, len=3, data beats 0xA0..0xA3, strb 0xFFFF, WREADY toggling 1/0 -> four beats in order; WLAST only on beat 3; AW handshake precedes the first WVALID; BVALID returns outstanding to 0.
- Write with len=7 and MAX_BEATS=4 -> no AWVALID/WVALID ever; err_len=1; packet_ready returns 1 the cycle after.
- Five read packets issued with ARREADY=1 and no R responses, MAX_OUTSTANDING=4 -> packet_ready=0 after the 4th AR handshake; the 5th is accepted only after one RLAST.
- BRESP=2'b10 on a write completion -> err_resp=1 and stays 1 until reset; a simultaneous RLAST and new AR handshake leaves outstanding unchanged.
- Assert M_AXI_ARESET during beat 2 of a 4-beat write -> the next cycle shows all VALIDs 0, outstanding=0, state IDLE; a fresh write afterwards completes normally.
